// File: rtl/blake2_feed_ctrl.sv
// rtl/blake2_feed_ctrl.sv - message/digest sequencer in front of a BLAKE2s compression core
module blake2_feed_ctrl #(
    parameter int W    = 32,
    parameter int NN_W = $clog2(W + 1),
    parameter int LL_W = 2 * W
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            cmd_v_i,
    output logic            cmd_ready_o,
    input  logic [NN_W-1:0] cmd_nn_i,
    input  logic            cmd_empty_i,
    output logic            cmd_err_o,
    input  logic            s_v_i,
    input  logic [7:0]      s_data_i,
    input  logic            s_last_i,
    output logic            s_ready_o,
    input  logic            core_ready_i,
    output logic            core_data_v_o,
    output logic [7:0]      core_data_o,
    output logic [5:0]      core_idx_o,
    output logic            core_first_o,
    output logic            core_last_o,
    output logic [LL_W-1:0] core_ll_o,
    output logic [NN_W-1:0] core_nn_o,
    output logic [NN_W-1:0] core_kk_o,
    input  logic            core_h_v_i,
    input  logic [7:0]      core_h_i,
    output logic            d_v_o,
    output logic [7:0]      d_data_o,
    output logic            d_last_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD, S_DIGEST} state_t;

    state_t          state_q, state_d;
    logic [LL_W-1:0] ll_q, ll_d;
    logic [5:0]      idx_q, idx_d;
    logic            first_q, first_d;
    logic            last_q, last_d;
    logic [NN_W-1:0] nn_q, nn_d;
    logic [NN_W-1:0] dcnt_q, dcnt_d;
    logic            err_q, err_d;
    logic            nn_ok;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            ll_q    <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            nn_q    <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ll_q    <= ll_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            last_q  <= last_d;
            nn_q    <= nn_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
        end
    end

    assign nn_ok       = (cmd_nn_i != '0) && (cmd_nn_i <= NN_W'(W));
    assign cmd_err_o   = err_q;
    assign core_nn_o   = nn_q;
    assign core_kk_o   = '0;
    assign core_idx_o  = idx_q;
    assign busy_o      = (state_q != S_IDLE);
    assign cmd_ready_o = (state_q == S_IDLE);

    always_comb begin
        state_d       = state_q;
        ll_d          = ll_q;
        idx_d         = idx_q;
        first_d       = first_q;
        last_d        = last_q;
        nn_d          = nn_q;
        dcnt_d        = dcnt_q;
        err_d         = 1'b0;
        s_ready_o     = 1'b0;
        core_data_v_o = 1'b0;
        core_data_o   = 8'h00;
        core_first_o  = first_q;
        core_last_o   = last_q;
        core_ll_o     = ll_q;
        d_v_o         = 1'b0;
        d_data_o      = 8'h00;
        d_last_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_v_i) begin
                    if (!nn_ok) begin
                        err_d = 1'b1;
                    end else begin
                        nn_d    = cmd_nn_i;
                        ll_d    = '0;
                        idx_d   = '0;
                        dcnt_d  = '0;
                        first_d = 1'b1;
                        last_d  = cmd_empty_i;
                        state_d = cmd_empty_i ? S_PAD : S_FILL;
                    end
                end
            end
            S_FILL: begin
                s_ready_o = core_ready_i;
                if (s_v_i && core_ready_i) begin
                    core_data_v_o = 1'b1;
                    core_data_o   = s_data_i;
                    core_last_o   = s_last_i | last_q;
                    ll_d          = ll_q + LL_W'(1);
                    idx_d         = idx_q + 6'd1;
                    // Present the final length already on the last data byte so it never moves afterwards.
                    core_ll_o     = ll_d;
                    if (s_last_i) begin
                        last_d  = 1'b1;
                        state_d = (idx_q == 6'd63) ? S_DIGEST : S_PAD;
                    end else if (idx_q == 6'd63) begin
                        first_d = 1'b0;
                    end
                end
            end
            S_PAD: begin
                core_last_o = 1'b1;
                if (core_ready_i) begin
                    core_data_v_o = 1'b1;
                    idx_d         = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_d = S_DIGEST;
                    end
                end
            end
            S_DIGEST: begin
                if (core_h_v_i) begin
                    d_v_o    = 1'b1;
                    d_data_o = core_h_i;
                    dcnt_d   = dcnt_q + NN_W'(1);
                    if (dcnt_d == nn_q) begin
                        d_last_o = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
